// File: rtl/abus_regbank_slave.sv
// abus_regbank_slave: bank of NB_REGS DATA_WIDTH-bit registers on the ABUS slave port.
// A request that hits [ADDR_BASE, ADDR_BASE+NB_REGS) is latched, held for
// WAIT_STATES cycles (abortable), then acknowledged with a one-cycle abus_sack.
// A write is committed at the edge that ends the ACK cycle, and only if
// WRITE_MID_MASK allows the requesting master id.
//
// Ports
//   abus_clk, abus_rst     : clock, synchronous active-high reset
//   abus_smid/sreq/swrite/sread/sabort/saddress/swdata : slave request side
//   abus_sack              : one-cycle completion pulse
//   abus_srdata/sstrb/skeep: read data, valid-bit count, transfer bit count (zero outside ACK)
//   reg_q                  : flattened register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr_pulse           : per-register pulse in the cycle after a committed write
//   wr_denied              : sticky, set when a write was refused by WRITE_MID_MASK
module abus_regbank_slave #(
    parameter int unsigned            ADDR_WIDTH     = 16,
    parameter int unsigned            DATA_WIDTH     = 16,
    parameter int unsigned            ADDR_BASE      = 0,
    parameter int unsigned            NB_REGS        = 8,
    parameter int unsigned            WAIT_STATES    = 0,
    parameter logic [7:0]             WRITE_MID_MASK = 8'hFF,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE    = '0
) (
    input  logic                               abus_clk,
    input  logic                               abus_rst,
    input  logic [2:0]                         abus_smid,
    input  logic                               abus_sreq,
    input  logic                               abus_swrite,
    input  logic                               abus_sread,
    input  logic                               abus_sabort,
    input  logic [ADDR_WIDTH-1:0]              abus_saddress,
    input  logic [DATA_WIDTH-1:0]              abus_swdata,
    output logic                               abus_sack,
    output logic [DATA_WIDTH-1:0]              abus_srdata,
    output logic [$clog2(DATA_WIDTH+1)-1:0]    abus_sstrb,
    output logic [$clog2(DATA_WIDTH+1)-1:0]    abus_skeep,
    output logic [NB_REGS*DATA_WIDTH-1:0]      reg_q,
    output logic [NB_REGS-1:0]                 reg_wr_pulse,
    output logic                               wr_denied
);

    localparam int unsigned STRB_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned IDX_W  = (NB_REGS > 1) ? $clog2(NB_REGS) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CMP_W  = ((ADDR_WIDTH > 32) ? ADDR_WIDTH : 32) + 1;

    // Address window computed one bit wider so ADDR_BASE+NB_REGS cannot wrap.
    localparam logic [CMP_W-1:0] ADDR_LO = CMP_W'(ADDR_BASE);
    localparam logic [CMP_W-1:0] ADDR_HI = CMP_W'(ADDR_BASE) + CMP_W'(NB_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    // Request captured at acceptance; live bus is ignored afterwards.
    typedef struct packed {
        logic [2:0]            mid;
        logic [IDX_W-1:0]      idx;
        logic                  wr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    req_t                   r_req;
    req_t                   w_req_nxt;

    logic [DATA_WIDTH-1:0]  r_regs [NB_REGS];
    logic                   r_sack;
    logic [DATA_WIDTH-1:0]  r_srdata;
    logic [STRB_W-1:0]      r_sstrb;
    logic [STRB_W-1:0]      r_skeep;
    logic [NB_REGS-1:0]     r_wr_pulse;
    logic                   r_wr_denied;

    logic [CMP_W-1:0]       w_addr_ext;
    logic                   w_hit;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_ack_nxt;
    logic                   w_rd_ack_nxt;
    logic                   w_commit;

    // Address decode
    always_comb begin
        w_addr_ext = CMP_W'(abus_saddress);
        w_hit      = abus_sreq & (abus_sread ^ abus_swrite)
                   & (w_addr_ext >= ADDR_LO) & (w_addr_ext < ADDR_HI);
        w_idx      = IDX_W'(w_addr_ext - ADDR_LO);
    end

    // Next state, wait counter and request latch
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_req_nxt.mid   = abus_smid;
                    w_req_nxt.idx   = w_idx;
                    w_req_nxt.wr    = abus_swrite;
                    w_req_nxt.wdata = abus_swdata;
                    if (WAIT_STATES > 0) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_W'(WAIT_STATES - 1);
                    end else begin
                        w_state_nxt = S_ACK;
                    end
                end
            end
            S_WAIT: begin
                // Abort wins over expiry in the last wait cycle.
                if (abus_sabort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with ACK.
    always_comb begin
        w_ack_nxt    = (w_state_nxt == S_ACK);
        w_rd_ack_nxt = w_ack_nxt & ~w_req_nxt.wr;
        w_commit     = (r_state == S_ACK) & r_req.wr;
    end

    // State, request, registers and outputs
    always_ff @(posedge abus_clk) begin
        if (abus_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req       <= '0;
            r_sack      <= 1'b0;
            r_srdata    <= '0;
            r_sstrb     <= '0;
            r_skeep     <= '0;
            r_wr_pulse  <= '0;
            r_wr_denied <= 1'b0;
            for (int i = 0; i < int'(NB_REGS); i++) begin
                r_regs[i] <= RESET_VALUE;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_req      <= w_req_nxt;
            r_sack     <= w_ack_nxt;
            r_srdata   <= w_rd_ack_nxt ? r_regs[w_req_nxt.idx] : '0;
            r_sstrb    <= w_rd_ack_nxt ? STRB_W'(DATA_WIDTH) : '0;
            r_skeep    <= w_ack_nxt ? STRB_W'(DATA_WIDTH) : '0;
            r_wr_pulse <= '0;
            if (w_commit) begin
                if (WRITE_MID_MASK[r_req.mid]) begin
                    r_regs[r_req.idx]     <= r_req.wdata;
                    r_wr_pulse[r_req.idx] <= 1'b1;
                end else begin
                    r_wr_denied <= 1'b1;
                end
            end
        end
    end

    // Flatten register array onto reg_q
    for (genvar g = 0; g < int'(NB_REGS); g++) begin : g_regq
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end

    assign abus_sack    = r_sack;
    assign abus_srdata  = r_srdata;
    assign abus_sstrb   = r_sstrb;
    assign abus_skeep   = r_skeep;
    assign reg_wr_pulse = r_wr_pulse;
    assign wr_denied    = r_wr_denied;

endmodule

// File: tb/tb_abus_regbank_slave.sv
// Testbench for abus_regbank_slave: directed scenarios plus random traffic,
// compared every cycle against a transaction-schedule model of the slave.
module tb_abus_regbank_slave;

    localparam int          DW   = 16;
    localparam int          NB   = 8;
    localparam int          BASE = 16;
    localparam int          WS   = 3;
    localparam logic [7:0]  MASK = 8'h05;
    localparam logic [15:0] RV   = 16'h5A5A;

    logic          clk;
    logic          rst;
    logic [2:0]    smid;
    logic          sreq, swrite, sread, sabort;
    logic [15:0]   saddr, swdata;
    logic          sack;
    logic [15:0]   srdata;
    logic [4:0]    sstrb, skeep;
    logic [127:0]  reg_q;
    logic [7:0]    wr_pulse;
    logic          wr_denied;

    int n_checks = 0;
    int n_fail   = 0;

    abus_regbank_slave #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (DW),
        .ADDR_BASE     (BASE),
        .NB_REGS       (NB),
        .WAIT_STATES   (WS),
        .WRITE_MID_MASK(MASK),
        .RESET_VALUE   (RV)
    ) dut (
        .abus_clk     (clk),
        .abus_rst     (rst),
        .abus_smid    (smid),
        .abus_sreq    (sreq),
        .abus_swrite  (swrite),
        .abus_sread   (sread),
        .abus_sabort  (sabort),
        .abus_saddress(saddr),
        .abus_swdata  (swdata),
        .abus_sack    (sack),
        .abus_srdata  (srdata),
        .abus_sstrb   (sstrb),
        .abus_skeep   (skeep),
        .reg_q        (reg_q),
        .reg_wr_pulse (wr_pulse),
        .wr_denied    (wr_denied)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: a transfer accepted at edge E acks in the cycle after edge E+WS,
    // commits at edge E+WS+1, and is cancelled by abort sampled at edges E+1..E+WS.
    logic [15:0]  m_regs [NB];
    bit           m_valid = 1'b0;
    bit           m_busy;
    bit           m_wr;
    int unsigned  m_edge = 0;
    int unsigned  m_ack_edge;
    logic [2:0]   m_mid;
    int           m_idx;
    logic [15:0]  m_wdata;
    bit           e_sack;
    logic [15:0]  e_srdata;
    logic [4:0]   e_sstrb, e_skeep;
    logic [7:0]   e_pulse;
    bit           e_denied;
    logic [127:0] e_regq;

    initial begin
        forever begin
            @(posedge clk);
            m_edge++;
            e_pulse = '0;
            if (rst) begin
                for (int i = 0; i < NB; i++) m_regs[i] = RV;
                m_busy   = 1'b0;
                m_wr     = 1'b0;
                m_idx    = 0;
                e_denied = 1'b0;
                m_valid  = 1'b1;
            end else if (m_valid) begin
                if (m_busy) begin
                    if (m_edge <= m_ack_edge && sabort) begin
                        m_busy = 1'b0;
                    end else if (m_edge == m_ack_edge + 1) begin
                        m_busy = 1'b0;
                        if (m_wr) begin
                            if (MASK[m_mid]) begin
                                m_regs[m_idx]  = m_wdata;
                                e_pulse[m_idx] = 1'b1;
                            end else begin
                                e_denied = 1'b1;
                            end
                        end
                    end
                end else if (sreq && (sread != swrite) &&
                             int'(saddr) >= BASE && int'(saddr) < BASE + NB) begin
                    m_busy     = 1'b1;
                    m_wr       = swrite;
                    m_mid      = smid;
                    m_idx      = int'(saddr) - BASE;
                    m_wdata    = swdata;
                    m_ack_edge = m_edge + WS;
                end
            end
            e_sack   = m_busy && (m_edge == m_ack_edge);
            e_skeep  = e_sack ? 5'd16 : 5'd0;
            e_sstrb  = (e_sack && !m_wr) ? 5'd16 : 5'd0;
            e_srdata = (e_sack && !m_wr) ? m_regs[m_idx] : 16'h0;
            for (int i = 0; i < NB; i++) e_regq[i*DW +: DW] = m_regs[i];
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("sack",      128'(sack),      128'(e_sack));
                chk("srdata",    128'(srdata),    128'(e_srdata));
                chk("sstrb",     128'(sstrb),     128'(e_sstrb));
                chk("skeep",     128'(skeep),     128'(e_skeep));
                chk("wr_pulse",  128'(wr_pulse),  128'(e_pulse));
                chk("wr_denied", 128'(wr_denied), 128'(e_denied));
                chk("reg_q",     reg_q,           e_regq);
            end
        end
    end

    task automatic bus_idle();
        sreq = 1'b0; sread = 1'b0; swrite = 1'b0; sabort = 1'b0;
    endtask

    // One request held for a single edge, then a bounded 12-cycle watch for sack.
    task automatic xfer(input logic [2:0] mid, input bit rd, input bit wr, input int addr,
                        input logic [15:0] d, input int abort_k, input int rst_k, input bit noisy,
                        output int lat, output logic [15:0] rdat,
                        output logic [4:0] rstrb, output logic [4:0] rkeep);
        @(negedge clk);
        smid = mid; sreq = 1'b1; sread = rd; swrite = wr;
        saddr = 16'(addr); swdata = d; sabort = 1'b0;
        lat = 0; rdat = '0; rstrb = '0; rkeep = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (sack && lat == 0) begin
                lat = k; rdat = srdata; rstrb = sstrb; rkeep = skeep;
            end
            sabort = (k == abort_k);
            rst    = (k == rst_k);
            if (noisy && k <= WS) begin
                sreq   = 1'($urandom);
                sread  = 1'($urandom);
                swrite = 1'($urandom);
                smid   = 3'($urandom);
                saddr  = 16'($urandom);
                swdata = 16'($urandom);
            end else begin
                sreq = 1'b0; sread = 1'b0; swrite = 1'b0;
            end
        end
    endtask

    int          lat, first, second;
    logic [15:0] rdat;
    logic [4:0]  rstrb, rkeep;

    initial begin
        rst = 1'b1; smid = '0; saddr = '0; swdata = '0;
        bus_idle();
        repeat (3) @(negedge clk);
        chk("rst_regq",   reg_q, {8{RV}});
        chk("rst_denied", 128'(wr_denied), 128'(0));
        chk("rst_sack",   128'(sack), 128'(0));
        rst = 1'b0;

        // Write reg 2 from mid 0, then read it back.
        xfer(3'd0, 1'b0, 1'b1, BASE + 2, 16'hA5A5, 0, 0, 1'b1, lat, rdat, rstrb, rkeep);
        chk("wr_lat",  128'(lat), 128'(4));
        chk("wr_keep", 128'(rkeep), 128'(16));
        chk("wr_reg2", 128'(reg_q[2*DW +: DW]), 128'(16'hA5A5));
        xfer(3'd1, 1'b1, 1'b0, BASE + 2, 16'h0, 0, 0, 1'b1, lat, rdat, rstrb, rkeep);
        chk("rd_lat",  128'(lat), 128'(4));
        chk("rd_data", 128'(rdat), 128'(16'hA5A5));
        chk("rd_strb", 128'(rstrb), 128'(16));
        chk("rd_keep", 128'(rkeep), 128'(16));

        // Abort in the second wait cycle, then confirm the old value survives.
        xfer(3'd0, 1'b0, 1'b1, BASE + 2, 16'h1111, 2, 0, 1'b0, lat, rdat, rstrb, rkeep);
        chk("abort_lat", 128'(lat), 128'(0));
        xfer(3'd0, 1'b1, 1'b0, BASE + 2, 16'h0, 0, 0, 1'b0, lat, rdat, rstrb, rkeep);
        chk("abort_rd", 128'(rdat), 128'(16'hA5A5));

        // Write from a master the mask refuses.
        xfer(3'd3, 1'b0, 1'b1, BASE + 5, 16'h1234, 0, 0, 1'b1, lat, rdat, rstrb, rkeep);
        chk("deny_lat",    128'(lat), 128'(4));
        chk("deny_reg5",   128'(reg_q[5*DW +: DW]), 128'(RV));
        chk("deny_sticky", 128'(wr_denied), 128'(1));

        // Requests that must never be acknowledged.
        xfer(3'd0, 1'b1, 1'b0, BASE + NB, 16'h0, 0, 0, 1'b0, lat, rdat, rstrb, rkeep);
        chk("miss_hi", 128'(lat), 128'(0));
        xfer(3'd0, 1'b1, 1'b0, BASE - 1, 16'h0, 0, 0, 1'b0, lat, rdat, rstrb, rkeep);
        chk("miss_lo", 128'(lat), 128'(0));
        xfer(3'd0, 1'b1, 1'b1, BASE + 1, 16'hFFFF, 0, 0, 1'b0, lat, rdat, rstrb, rkeep);
        chk("rdwr_both", 128'(lat), 128'(0));
        xfer(3'd0, 1'b0, 1'b0, BASE + 1, 16'hFFFF, 0, 0, 1'b0, lat, rdat, rstrb, rkeep);
        chk("rdwr_none", 128'(lat), 128'(0));

        // Back-to-back writes to regs 0 and 1 with sreq held continuously.
        @(negedge clk);
        smid = 3'd2; sreq = 1'b1; swrite = 1'b1; sread = 1'b0;
        saddr = 16'(BASE); swdata = 16'hC0C0;
        first = 0; second = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (sack) begin
                if (first == 0) first = k;
                else if (second == 0) second = k;
            end
            if (k == 1) begin saddr = 16'(BASE + 1); swdata = 16'hC1C1; end
            if (k == 6) bus_idle();
        end
        chk("b2b_first",  128'(first), 128'(4));
        chk("b2b_second", 128'(second), 128'(9));
        chk("b2b_reg0",   128'(reg_q[0 +: DW]), 128'(16'hC0C0));
        chk("b2b_reg1",   128'(reg_q[DW +: DW]), 128'(16'hC1C1));

        // Reset while a write is waiting.
        xfer(3'd0, 1'b0, 1'b1, BASE + 3, 16'h7777, 0, 2, 1'b0, lat, rdat, rstrb, rkeep);
        chk("rstw_lat",    128'(lat), 128'(0));
        chk("rstw_regq",   reg_q, {8{RV}});
        chk("rstw_denied", 128'(wr_denied), 128'(0));

        // Random traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 299) == 0);
            sreq   = ($urandom_range(0, 2) != 0);
            sread  = 1'($urandom);
            swrite = 1'($urandom);
            smid   = 3'($urandom);
            saddr  = 16'(BASE - 2 + int'($urandom_range(0, NB + 3)));
            swdata = 16'($urandom);
            sabort = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        bus_idle();
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/abus_regbank_slave.md
ABUS_REGBANK_SLAVE -- requirements
Module: abus_regbank_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, address bus width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data bus width.
REQ-003 SHALL have parameter ADDR_BASE, default 0, word address of register 0.
REQ-004 SHALL have parameter NB_REGS, default 8, number of registers, range 1..256.
REQ-005 SHALL have parameter WAIT_STATES, default 0, extra cycles before ack, range 0..15.
REQ-006 SHALL have parameter WRITE_MID_MASK, default 8'hFF, bit m set = master id m may write.
REQ-007 SHALL have parameter RESET_VALUE, default 0, DATA_WIDTH-bit reset value of every register.
REQ-008 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-009 abus_clk  in  1  bus clock, all logic on rising edge.
REQ-010 abus_rst  in  1  synchronous active-high reset.
REQ-011 abus_smid  in  3  master id of granted request.
REQ-012 abus_sreq  in  1  request valid.
REQ-013 abus_swrite  in  1  write qualifier.
REQ-014 abus_sread  in  1  read qualifier.
REQ-015 abus_sabort  in  1  master aborts outstanding request.
REQ-016 abus_saddress  in  ADDR_WIDTH  word address.
REQ-017 abus_swdata  in  DATA_WIDTH  write data.
REQ-018 abus_sack  out  1  one-cycle completion pulse.
REQ-019 abus_srdata  out  DATA_WIDTH  read data, valid only with abus_sack.
REQ-020 abus_sstrb  out  $clog2(DATA_WIDTH+1)  count of valid read-data bits.
REQ-021 abus_skeep  out  $clog2(DATA_WIDTH+1)  count of bits consumed/produced by the transfer.
REQ-022 reg_q  out  NB_REGS*DATA_WIDTH  current register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-023 reg_wr_pulse  out  NB_REGS  one-cycle pulse per register on committed write.
REQ-024 wr_denied  out  1  sticky flag, a write was refused by WRITE_MID_MASK.

Function
REQ-025 Hit SHALL be abus_sreq & (abus_sread ^ abus_swrite) & ADDR_BASE <= abus_saddress < ADDR_BASE+NB_REGS; index = abus_saddress-ADDR_BASE.
REQ-026 FSM states SHALL be IDLE, WAIT, ACK.
REQ-027 IDLE: on hit, latch mid, index, read/write, wdata; go WAIT if WAIT_STATES>0 (load counter WAIT_STATES-1) else ACK; otherwise stay IDLE.
REQ-028 WAIT: counter decrements each cycle; at 0 go ACK; abus_sabort high in any WAIT cycle -> IDLE, no ack, no write, no pulse.
REQ-029 ACK: abus_sack=1 for exactly one cycle, then IDLE unconditionally; abus_sabort in ACK is ignored.
REQ-030 Latency: hit sampled at edge N -> abus_sack high in cycle N+1+WAIT_STATES.
REQ-031 Write commit SHALL occur at the edge ending the ACK cycle; reg_wr_pulse[index] high during the cycle after that edge; latched wdata used, not live bus.
REQ-032 Write with WRITE_MID_MASK[mid]=0 SHALL be acked, SHALL NOT update register or pulse, SHALL set wr_denied.
REQ-033 Read: abus_srdata = latched-index register value during ACK, abus_sstrb=DATA_WIDTH; write ack: abus_srdata=0, abus_sstrb=0.
REQ-034 abus_skeep SHALL be DATA_WIDTH during ACK, 0 otherwise; abus_srdata and abus_sstrb SHALL be 0 outside ACK (OR-mux safe).
REQ-035 Miss, read&write both set, or read&write both clear SHALL produce no ack and no state change.
REQ-036 New request SHALL be accepted in the first IDLE cycle after ACK (back-to-back, no bubble beyond ACK->IDLE).
REQ-037 Inputs changing during WAIT SHALL NOT affect the outstanding transfer.

Reset
REQ-038 With abus_rst high at an edge: state IDLE, counter 0, all registers RESET_VALUE, wr_denied 0, abus_sack/srdata/sstrb/skeep/reg_wr_pulse 0.
REQ-039 Reset during WAIT or ACK SHALL drop the transfer with no ack and no write.

Verification
REQ-040 WAIT_STATES=0: write mid=0 addr ADDR_BASE+2 data 16'hA5A5 -> sack cycle N+1, reg 2=16'hA5A5, reg_wr_pulse=8'b0000_0100 one cycle.
REQ-041 WAIT_STATES=3: read addr ADDR_BASE+2 -> sack cycle N+4, srdata=16'hA5A5, sstrb=16, skeep=16.
REQ-042 WAIT_STATES=3: write, sabort in second WAIT cycle -> no sack, reg unchanged, no pulse; next read returns old value.
REQ-043 WRITE_MID_MASK=8'h01: write from mid=3 data 16'h1234 -> sack, register unchanged, wr_denied=1 until reset.
REQ-044 Address ADDR_BASE+NB_REGS, and sread=swrite=1 -> no sack ever; back-to-back writes to regs 0,1 -> sacks in cycles N+1 and N+3.
REQ-045 abus_rst asserted in WAIT -> no sack, all reg_q=RESET_VALUE, wr_denied=0 next cycle.
